// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types for the dual-core memory arbiter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  // Encoding matters: bit 1 = instruction slot, bit 0 = CPU index.
  typedef enum logic [1:0] {D0, D1, I0, I1} arb_slot_t;

  typedef enum logic [1:0] {IDLE, GRANT, BURST} arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side request/response and RAM command bus of the memory arbiter.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic [1:0]      iREN;
  logic [1:0]      dREN;
  logic [1:0]      dWEN;
  word_t [1:0]     iaddr;
  word_t [1:0]     daddr;
  word_t [1:0]     dstore;
  logic [1:0]      iwait;
  logic [1:0]      dwait;
  word_t [1:0]     iload;
  word_t [1:0]     dload;

  logic            ramREN;
  logic            ramWEN;
  word_t           ramaddr;
  word_t           ramstore;
  word_t           ramload;
  ramstate_t       ramstate;

  // Arbiter side.
  modport slave (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  // CPU caches and RAM model side.
  modport master (
    output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/arb_select.sv
// Combinational slot picker: data beats instruction, rr picks the CPU among same-type requests.
module arb_select
  import cpu_types_pkg::*;
(
  input  logic [3:0] i_active,  // indexed by arb_slot_t
  input  logic       i_rr,
  output arb_slot_t  o_slot,
  output logic       o_valid
);

  logic [1:0] w_dact;
  logic [1:0] w_iact;
  logic       w_cpu;

  assign w_dact = i_active[1:0];
  assign w_iact = i_active[3:2];

  // Preferred CPU wins if it is asking, otherwise the other one.
  function automatic logic pick_cpu(input logic [1:0] act, input logic rr);
    return act[rr] ? rr : ~rr;
  endfunction

  always_comb begin
    o_valid = |i_active;
    w_cpu   = 1'b0;
    o_slot  = D0;
    if (|w_dact) begin
      w_cpu  = pick_cpu(w_dact, i_rr);
      o_slot = arb_slot_t'({1'b0, w_cpu});
    end else if (|w_iact) begin
      w_cpu  = pick_cpu(w_iact, i_rr);
      o_slot = arb_slot_t'({1'b1, w_cpu});
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-CPU I/D memory arbiter holding dcache grants for BURST_LEN words.
// Define MEM_ARB_RR_EN for round-robin CPU selection; otherwise CPU0 has fixed priority.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned BURST_LEN = 2
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned BcntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  arb_state_t       r_state, w_state_nxt;
  arb_slot_t        r_gsel, w_gsel_nxt, w_win;
  logic [BcntW-1:0] r_bcnt, w_bcnt_nxt;

  logic [3:0] w_active;
  logic       w_win_valid;
  logic       w_rr;
  logic       w_granted;
  logic       w_is_instr;
  logic       w_cpu;
  logic       w_req;
  logic       w_done;
  logic       w_last;

  assign w_active   = {bus.iREN, bus.dREN | bus.dWEN};
  assign w_granted  = (r_state != IDLE);
  assign w_is_instr = r_gsel[1];
  assign w_cpu      = r_gsel[0];
  assign w_req      = w_active[r_gsel];
  assign w_done     = w_granted & w_req & (bus.ramstate == ACCESS);
  assign w_last     = w_done & ~w_is_instr & (r_bcnt == BcntW'(BURST_LEN - 1));

`ifdef MEM_ARB_RR_EN
  logic r_rr;

  // Pointer only moves when a whole data burst has gone through.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rr <= 1'b0;
    end else if (w_last) begin
      r_rr <= ~r_rr;
    end
  end

  assign w_rr = r_rr;
`else
  assign w_rr = 1'b0;
`endif

  arb_select u_arb_select (
    .i_active (w_active),
    .i_rr     (w_rr),
    .o_slot   (w_win),
    .o_valid  (w_win_valid)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_gsel  <= D0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gsel  <= w_gsel_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gsel_nxt  = r_gsel;
    w_bcnt_nxt  = r_bcnt;
    unique case (r_state)
      IDLE: begin
        if (w_win_valid) begin
          w_gsel_nxt  = w_win;
          w_bcnt_nxt  = '0;
          w_state_nxt = GRANT;
        end
      end
      GRANT, BURST: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
        end else if (w_done) begin
          if (w_is_instr || w_last) begin
            w_state_nxt = IDLE;
          end else begin
            w_bcnt_nxt  = r_bcnt + 1'b1;
            w_state_nxt = BURST;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // RAM bus follows the holder's live request; completion opens its wait for one cycle.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 2'b11;
    bus.dwait    = 2'b11;
    bus.iload    = '0;
    bus.dload    = '0;
    if (w_granted) begin
      if (w_is_instr) begin
        bus.ramaddr = bus.iaddr[w_cpu];
        bus.ramREN  = bus.iREN[w_cpu];
        if (w_done) begin
          bus.iwait[w_cpu] = 1'b0;
          bus.iload[w_cpu] = bus.ramload;
        end
      end else begin
        bus.ramaddr  = bus.daddr[w_cpu];
        bus.ramstore = bus.dstore[w_cpu];
        bus.ramWEN   = bus.dWEN[w_cpu];
        bus.ramREN   = bus.dREN[w_cpu] & ~bus.dWEN[w_cpu];
        if (w_done) begin
          bus.dwait[w_cpu] = 1'b0;
          bus.dload[w_cpu] = bus.ramload;
        end
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: BURST_LEN, 2, number of consecutive dcache word accesses held under one grant (the dcache block size in words).
REQ-002 Ports: CLK in 1, the single clock; nRST in 1, asynchronous active-low reset.
REQ-003 iREN in [2], per-CPU instruction read request; iaddr in [2]x32, per-CPU instruction word address.
REQ-004 dREN in [2], dWEN in [2], per-CPU data read and write requests; daddr in [2]x32 and dstore in [2]x32, per-CPU data address and write data.
REQ-005 iwait out [2], dwait out [2], per-CPU stall, high = not done; iload out [2]x32, dload out [2]x32, per-CPU read data.
REQ-006 ramREN out 1, ramWEN out 1, ramaddr out 32, ramstore out 32: RAM command bus.
REQ-007 ramload in 32, RAM read data; ramstate in 2, a ramstate_t value from the set FREE, BUSY, ACCESS, ERROR.

Function
REQ-008 Requester slots SHALL be D0, D1, I0, I1; a data slot is active when dREN|dWEN is high, and an instruction slot is active when iREN is high.
REQ-009 The FSM SHALL have three states, IDLE, GRANT and BURST, with the grant holder recorded in registers gsel (slot) and bcnt (burst word count).
REQ-010 In IDLE the FSM SHALL select the highest-priority active slot, register it into gsel, set bcnt=0 and move to GRANT the next cycle; no RAM command SHALL be issued in IDLE.
REQ-011 Data slots SHALL beat instruction slots, and among same-type slots the slot named by the round-robin pointer rr SHALL win (see REQ-020).
REQ-012 In GRANT and BURST, the RAM bus SHALL be driven combinationally from the live signals of slot gsel: ramREN = dREN or iREN, ramWEN = dWEN, ramaddr, and ramstore (dstore for data slots, 0 otherwise).
REQ-013 If dREN and dWEN are both high on a data slot, write SHALL win and ramREN SHALL be 0.
REQ-014 When ramstate==ACCESS, the wait of slot gsel SHALL be low that same cycle, and iload/dload of that CPU SHALL equal ramload.
REQ-015 Every wait that is not completing in the current cycle SHALL be 1.
REQ-016 When a data word completes with bcnt<BURST_LEN-1: bcnt SHALL increment, the FSM SHALL move to BURST, and the grant SHALL stay on that CPU with no re-arbitration.
REQ-017 When a data word completes with bcnt==BURST_LEN-1, and whenever an instruction access completes, the FSM SHALL return to IDLE.
REQ-018 If the holder drops its request in GRANT or BURST before ACCESS, the RAM enables SHALL fall with it and the FSM SHALL return to IDLE the next cycle with no completion counted.
REQ-019 ramstate ERROR, BUSY or FREE while granted SHALL keep the holder's wait high and leave the state unchanged, so the access is retried.
REQ-020 rr (1 bit) SHALL toggle only when a data burst finishes; instruction grants SHALL use the same rr.
REQ-021 Unselected iload/dload outputs SHALL be 0.

Reset
REQ-022 With nRST low, state SHALL be IDLE, gsel=D0, bcnt=0 and rr=0, asynchronously.
REQ-023 With nRST low, ramREN=ramWEN=0, ramaddr=ramstore=0, all waits=1 and all loads=0.
REQ-024 Reset asserted mid-burst SHALL abandon the burst, with no partial completion reported after release.

Configuration
REQ-025 With MEM_ARB_RR_EN defined, CPU selection SHALL be round-robin as specified in REQ-011 and REQ-020.
REQ-026 Without MEM_ARB_RR_EN, CPU0 SHALL have fixed priority within each type, rr SHALL be removed, and all other behaviour SHALL be unchanged.

Structure
REQ-027 ramstate_t, word_t and a new arb_slot_t enum (D0, D1, I0, I1) SHALL live in cpu_types_pkg.
REQ-028 One sub-module, arb_select, SHALL be used: combinational priority and round-robin pick from the 4 active bits plus rr, returning the winning slot and a valid flag.

Verification
REQ-029 Single dREN with daddr=0x40 and BURST_LEN=2: the bench SHALL drive ACCESS twice, the dcache raises 0x44 on the second word, and it SHALL see dwait[0] low twice, both words reach ramaddr, then IDLE.
REQ-030 dREN[0] and iREN[1] raised in the same cycle: the full D0 burst SHALL complete before I1 gets ramREN, and iwait[1] SHALL stay 1 throughout the burst.
REQ-031 dWEN on both CPUs continuously with the macro defined: grants SHALL alternate D0, D1, D0 burst by burst; without the macro, D0 SHALL win every time.
REQ-032 ramstate=ERROR for 3 cycles then ACCESS: the same address SHALL be held and dwait SHALL drop only on the ACCESS cycle.
REQ-033 The holder drops dREN mid-burst: ramREN SHALL drop the same cycle and the FSM SHALL be IDLE next cycle.
REQ-034 nRST pulsed low during BURST: all outputs SHALL take reset values immediately, and after release a new request SHALL be granted normally.
